// File: rtl/hello_scroll_pkg.sv
// rtl/hello_scroll_pkg.sv - shared types, constants and wrap helper for the HELLO scroll sequencer
package hello_scroll_pkg;

    localparam int NUM_POS = 5;
    localparam int SEL_W   = 3;

    typedef enum logic [1:0] {
        PAUSE     = 2'b00,
        RUN       = 2'b01,
        STEP_WAIT = 2'b10
    } state_t;

    // One rotation step with wrap; dir=0 counts up, dir=1 counts down.
    // The >= on the up path keeps a corrupted sel from running past the last position.
    function automatic logic [SEL_W-1:0] next_sel(input logic [SEL_W-1:0] sel, input logic dir);
        logic [SEL_W-1:0] result;
        if (dir) begin
            result = (sel == '0) ? SEL_W'(NUM_POS - 1) : sel - SEL_W'(1);
        end else begin
            result = (sel >= SEL_W'(NUM_POS - 1)) ? '0 : sel + SEL_W'(1);
        end
        return result;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - programmable timebase counter with terminal-count pulse
//   clk, resetn   : clock, synchronous active-low reset
//   en            : count enable
//   clr           : synchronous clear (wins over en)
//   limit         : period in cycles (>= 1)
//   terminal      : high in the last cycle of each period while enabled
module tick_prescaler #(
    parameter int CNT_W = 25
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             en,
    input  logic             clr,
    input  logic [CNT_W-1:0] limit,
    output logic             terminal
);

    logic [CNT_W-1:0] cnt;

    // >= rather than == so a shortened limit mid-count fires at once instead of
    // wrapping through the full counter range.
    assign terminal = en && (cnt >= limit - CNT_W'(1));

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            if (terminal) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/hello_scroll_ctrl.sv
// rtl/hello_scroll_ctrl.sv - run/pause/single-step sequencer driving the HELLO rotator select
//   CLOCK_50, resetn : clock, synchronous active-low reset
//   run              : 1 = auto-scroll, 0 = pause
//   dir              : 0 = sel counts up, 1 = sel counts down
//   step             : push-button level (active high), rising edge steps once in pause
//   speed            : step period = TICK_DIV >> speed
//   sel              : rotation select to the rotator
//   tick             : one-cycle pulse coincident with each new sel
//   state            : FSM state for debug LEDs
//   blank            : (HELLO_SCROLL_BLINK_EN only) blink-off flag while paused
module hello_scroll_ctrl
    import hello_scroll_pkg::*;
#(
    parameter int TICK_DIV = 25000000,
    parameter int CNT_W    = 25
) (
    input  logic             CLOCK_50,
    input  logic             resetn,
    input  logic             run,
    input  logic             dir,
    input  logic             step,
    input  logic [1:0]       speed,
    output logic [SEL_W-1:0] sel,
    output logic             tick,
    output logic [1:0]       state
`ifdef HELLO_SCROLL_BLINK_EN
    ,
    output logic             blank
`endif
);

    localparam logic [CNT_W-1:0] TICK_DIV_W = CNT_W'(TICK_DIV);

    state_t           state_q;
    logic             step_q;
    logic             step_rise;
    logic [CNT_W-1:0] shifted;
    logic [CNT_W-1:0] limit;
    logic             pre_en;
    logic             pre_clr;
    logic             terminal;

    assign step_rise = step & ~step_q;
    assign shifted   = TICK_DIV_W >> speed;
    assign limit     = (shifted == '0) ? CNT_W'(1) : shifted;
    assign state     = state_q;

`ifdef HELLO_SCROLL_BLINK_EN
    logic go_run;
    logic leave_run;

    // step_rise has priority over run, so PAUSE only heads to RUN without a press.
    assign go_run    = (state_q == PAUSE) && !step_rise && run;
    assign leave_run = (state_q == RUN) && !run;
    // Counter free-runs in every legal state except on the RUN boundaries.
    assign pre_clr   = go_run || leave_run ||
                       !((state_q == PAUSE) || (state_q == RUN) || (state_q == STEP_WAIT));
    assign pre_en    = !pre_clr;
`else
    assign pre_en    = (state_q == RUN) && run;
    assign pre_clr   = !pre_en;
`endif

    tick_prescaler #(
        .CNT_W (CNT_W)
    ) u_prescaler (
        .clk      (CLOCK_50),
        .resetn   (resetn),
        .en       (pre_en),
        .clr      (pre_clr),
        .limit    (limit),
        .terminal (terminal)
    );

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            state_q <= PAUSE;
            sel     <= '0;
            tick    <= 1'b0;
            step_q  <= 1'b0;
        end else begin
            step_q <= step;
            tick   <= 1'b0;
            case (state_q)
                PAUSE: begin
                    if (step_rise) begin
                        sel     <= next_sel(sel, dir);
                        tick    <= 1'b1;
                        state_q <= STEP_WAIT;
                    end else if (run) begin
                        state_q <= RUN;
                    end
                end
                STEP_WAIT: begin
                    if (!step) begin
                        state_q <= PAUSE;
                    end
                end
                RUN: begin
                    if (!run) begin
                        state_q <= PAUSE;
                    end else if (terminal) begin
                        sel  <= next_sel(sel, dir);
                        tick <= 1'b1;
                    end
                end
                default: begin
                    state_q <= PAUSE;
                end
            endcase
        end
    end

`ifdef HELLO_SCROLL_BLINK_EN
    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            blank <= 1'b0;
        end else if (go_run || (state_q == RUN)) begin
            blank <= 1'b0;
        end else if (terminal && ((state_q == PAUSE) || (state_q == STEP_WAIT))) begin
            blank <= ~blank;
        end
    end
`endif

endmodule

// File: tb/tb_hello_scroll_ctrl.sv
// tb/tb_hello_scroll_ctrl.sv - directed self-checking bench for hello_scroll_ctrl (TICK_DIV=8)
module tb_hello_scroll_ctrl;

    logic       clk;
    logic       resetn;
    logic       run;
    logic       dir;
    logic       step;
    logic [1:0] speed;
    logic [2:0] sel;
    logic       tick;
    logic [1:0] state;
`ifdef HELLO_SCROLL_BLINK_EN
    logic       blank;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int n;

    hello_scroll_ctrl #(
        .TICK_DIV (8),
        .CNT_W    (4)
    ) dut (
        .CLOCK_50 (clk),
        .resetn   (resetn),
        .run      (run),
        .dir      (dir),
        .step     (step),
        .speed    (speed),
        .sel      (sel),
        .tick     (tick),
        .state    (state)
`ifdef HELLO_SCROLL_BLINK_EN
        ,
        .blank    (blank)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Cycles until the next tick, bounded; a timeout shows up as a bad gap.
    task automatic wait_tick(output int cnt);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!tick && cnt < 20);
    endtask

    task automatic press(input logic [31:0] exp_sel);
        step = 1'b1;
        @(negedge clk);
        check("press_sel", sel, exp_sel);
        check("press_tick", tick, 1);
        check("press_state", state, 2);
        @(negedge clk);
        check("press_tick_low", tick, 0);
        @(negedge clk);
        step = 1'b0;
        @(negedge clk);
        check("release_state", state, 0);
    endtask

`ifdef HELLO_SCROLL_BLINK_EN
    task automatic wait_blank(input logic v, output int cnt);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (blank !== v && cnt < 20);
    endtask
`endif

    always @(negedge clk) begin
        if (resetn) check("sel_range", {31'b0, sel > 3'd4}, 0);
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int up_seq[5];
        int dn_seq[2];
        up_seq = '{1, 2, 3, 4, 0};
        dn_seq = '{4, 3};

        resetn = 1'b0; run = 1'b0; dir = 1'b0; step = 1'b0; speed = 2'd0;
        repeat (2) @(negedge clk);
        check("rst_sel", sel, 0);
        check("rst_tick", tick, 0);
        check("rst_state", state, 0);

        resetn = 1'b1; run = 1'b1;
        @(negedge clk);
        check("to_run", state, 1);
        for (int i = 0; i < 5; i++) begin
            wait_tick(n);
            check("up_gap", n, 8);
            check("up_sel", sel, up_seq[i]);
        end

        dir = 1'b1;
        for (int i = 0; i < 2; i++) begin
            wait_tick(n);
            check("dn_gap", n, 8);
            check("dn_sel", sel, dn_seq[i]);
        end

        // counter reaches 6, then limit drops to 2
        dir = 1'b0;
        repeat (6) @(negedge clk);
        check("pre_speed_tick", tick, 0);
        speed = 2'd2;
        @(negedge clk);
        check("speed_tick", tick, 1);
        check("speed_sel", sel, 4);
        wait_tick(n);
        check("fast_gap0", n, 2);
        check("fast_sel0", sel, 0);
        wait_tick(n);
        check("fast_gap1", n, 2);
        check("fast_sel1", sel, 1);
        speed = 2'd0;

        wait_tick(n);
        check("pre_rst_sel2", sel, 2);
        wait_tick(n);
        check("pre_rst_sel3", sel, 3);
        repeat (5) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        check("midrst_sel", sel, 0);
        check("midrst_state", state, 0);
        check("midrst_tick", tick, 0);
        resetn = 1'b1; run = 1'b0;
        @(negedge clk);
        check("post_rst_sel", sel, 0);
        check("post_rst_state", state, 0);

        press(1);
        press(2);
        step = 1'b1;
        @(negedge clk);
        check("hold_first_sel", sel, 3);
        repeat (19) @(negedge clk);
        check("hold_sel", sel, 3);
        check("hold_state", state, 2);
        step = 1'b0;
        @(negedge clk);
        check("hold_release", state, 0);

        // step and run together: step wins, run waits for release
        step = 1'b1; run = 1'b1;
        @(negedge clk);
        check("prio_state", state, 2);
        check("prio_sel", sel, 4);
        @(negedge clk);
        check("prio_wait", state, 2);
        step = 1'b0;
        @(negedge clk);
        check("prio_pause", state, 0);
        @(negedge clk);
        check("prio_run", state, 1);

        run = 1'b0;
        @(negedge clk);
        check("stop_state", state, 0);
        check("stop_sel", sel, 4);

`ifdef HELLO_SCROLL_BLINK_EN
        wait_blank(1'b1, n);
        check("blink_on_gap", n, 8);
        wait_blank(1'b0, n);
        check("blink_off_gap", n, 8);
        wait_blank(1'b1, n);
        check("blink_on_gap2", n, 8);
        check("blink_sel", sel, 4);
        run = 1'b1;
        @(negedge clk);
        check("blink_run_blank", blank, 0);
        check("blink_run_state", state, 1);
        wait_tick(n);
        check("blink_resume_gap", n, 8);
        check("blink_resume_sel", sel, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hello_scroll_ctrl.md
Name: hello_scroll_ctrl

Overview:
- Sequencer for the 5-digit HELLO rotating display.
- Drives the 3-bit rotation select `s` of the existing rotator/decoder datapath.
- The rotator shows position 0..4. This block advances the position automatically on a programmable timebase, or one step per push-button press.
- Sits between board switches/keys and the rotator; the rotator and 7-segment decode are untouched.

Parameters:
- TICK_DIV, 25000000: base clock cycles per rotation step at speed 0 (0.5 s at 50 MHz).
- NUM_POS, 5: number of rotation positions; sel range is 0..NUM_POS-1.
- SEL_W, 3: width of sel.
- CNT_W, 25: prescaler counter width; must satisfy 2^CNT_W >= TICK_DIV.

Ports:
- CLOCK_50 in 1: single system clock, all logic on rising edge.
- resetn in 1: reset, synchronous, active-low.
- run in 1: level; 1 = auto-scroll, 0 = pause.
- dir in 1: 0 = sel increments (text moves left); 1 = sel decrements.
- step in 1: active-high push-button level, already inverted from KEY. Rising edge detected internally.
- speed in 2: step period = TICK_DIV >> speed (speed 3 is 8x faster).
- sel out SEL_W: rotation select to the rotator `s` input.
- tick out 1: one-cycle pulse on every sel change.
- state out 2: current FSM state, for LED debug.

Behaviour:
- Reset (resetn=0 sampled at a clock edge): sel=0, tick=0, state=PAUSE, counter=0, step_q=0. Reset mid-run takes effect on that edge; no partial step completes.
- step_q is a registered copy of step. step_rise = step & ~step_q.
- limit = TICK_DIV >> speed, computed combinationally, minimum 1.
- Advance operation:
  - dir=0: sel <= (sel==NUM_POS-1) ? 0 : sel+1.
  - dir=1: sel <= (sel==0) ? NUM_POS-1 : sel-1.
  - sel never takes values NUM_POS..7.
- tick is registered and asserts in the same cycle sel shows its new value. Zero added latency to the rotator, which is combinational.
- FSM states: PAUSE=2'b00, RUN=2'b01, STEP_WAIT=2'b10. Encoding 2'b11 is unreachable; if entered, go to PAUSE.
- PAUSE:
  - Counter held at 0.
  - step_rise -> one advance, tick=1, go to STEP_WAIT.
  - else run=1 -> RUN.
  - step_rise takes priority over run in the same cycle.
- STEP_WAIT:
  - No advance.
  - step=0 -> PAUSE.
  - run is ignored until release (then PAUSE -> RUN next cycle).
- RUN:
  - run=0 -> PAUSE, counter cleared, no advance that cycle even if terminal.
  - Otherwise counter increments. When counter >= limit-1: counter <= 0, advance, tick=1.
  - step is ignored in RUN.
- Speed change mid-count: the >= compare forces an immediate advance if the count already exceeds the new limit. No hang, no wrap through 2^CNT_W.
- dir change is applied at the next advance only. No retroactive correction.
- In RUN with limit=1, sel advances every cycle and tick stays high continuously.

Optional Feature:
- Macro: HELLO_SCROLL_BLINK_EN.
- When defined:
  - Extra output port `blank out 1`.
  - In PAUSE and STEP_WAIT the prescaler keeps counting. blank toggles at each terminal count and sel does not change.
  - In RUN, blank=0.
  - blank resets to 0.
  - Entering RUN forces blank=0 and clears the counter.
  - The top level ORs blank into all HEX outputs as all-ones (segments off).
- When undefined: no blank port, counter held at 0 outside RUN, behaviour exactly as above.

Decomposition:
- Package hello_scroll_pkg:
  - state typedef (PAUSE/RUN/STEP_WAIT, 2-bit encodings above).
  - NUM_POS, SEL_W constants.
  - function next_sel(sel, dir) for the wrap arithmetic.
- One sub-module: tick_prescaler.
  - Inputs: clk, resetn, en, clr, limit.
  - Output: terminal pulse.
  - Holds the counter and the >= compare.
- FSM, edge detect and sel register stay in hello_scroll_ctrl.

Test Plan (bench uses TICK_DIV=8):
- Reset, then run=1, dir=0, speed=0: sel 0->1->2->3->4->0, one step every 8 cycles. tick high exactly the cycle each new sel appears.
- run=1, dir=1 from sel=0: first advance gives sel=4, then 3. No value above 4 ever appears.
- run=0, step pulsed high 3 cycles, twice: sel advances by exactly 1 per press, states PAUSE->STEP_WAIT->PAUSE. step held high 20 cycles gives a single advance.
- RUN at speed=0, counter at 6, speed switched to 2 (limit 2): advance on the next edge, then every 2 cycles.
- resetn=0 for one edge during RUN at sel=3, counter=5: next cycle sel=0, state=PAUSE, tick=0. No advance from the interrupted count.
- HELLO_SCROLL_BLINK_EN defined, PAUSE: blank toggles every 8 cycles with sel constant. Set run=1: blank=0 on the next cycle and scrolling resumes.
